// File: rtl/compteur_rondes_param.sv
// Round counter/sequencer for the ASCON permutation: start -> RUN in 1 clock, ROUNDS_sel RUN cycles then 1 DONE cycle.
// en_i low freezes the count and all flags; abort_i returns to IDLE with priority over start_i and en_i.
module compteur_rondes_param #(
  parameter int WIDTH         = 4,
  parameter int NB_ROUNDS_MAX = 12,
  parameter int ROUNDS_A      = 12,
  parameter int ROUNDS_B      = 6,
  parameter int ROUNDS_C      = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic             en_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] cpt_o,
  output logic             busy_o,
  output logic             first_round_o,
  output logic             last_round_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] LAST   = WIDTH'(NB_ROUNDS_MAX - 1);
  localparam logic [WIDTH-1:0] INIT_A = WIDTH'(NB_ROUNDS_MAX - ROUNDS_A);
  localparam logic [WIDTH-1:0] INIT_B = WIDTH'(NB_ROUNDS_MAX - ROUNDS_B);
  localparam logic [WIDTH-1:0] INIT_C = WIDTH'(NB_ROUNDS_MAX - ROUNDS_C);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cpt, cpt_nxt;
  logic [WIDTH-1:0] start_idx, start_idx_nxt;
  logic             err_q, err_nxt;
  logic             mode_ok;
  logic [WIDTH-1:0] init_sel;

  always_comb begin
    mode_ok  = 1'b1;
    init_sel = INIT_A;
    case (mode_i)
      2'b00:   init_sel = INIT_A;
      2'b01:   init_sel = INIT_B;
      2'b10:   init_sel = INIT_C;
      default: mode_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state     <= IDLE;
      cpt       <= '0;
      start_idx <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpt       <= cpt_nxt;
      start_idx <= start_idx_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cpt_nxt       = cpt;
    start_idx_nxt = start_idx;
    err_nxt       = 1'b0;
    if (abort_i) begin
      state_nxt = IDLE;
      cpt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (mode_ok) begin
              state_nxt     = RUN;
              cpt_nxt       = init_sel;
              start_idx_nxt = init_sel;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          // A start during a run is refused but never disturbs the count.
          err_nxt = start_i;
          if (en_i) begin
            if (cpt == LAST) state_nxt = DONE;
            else             cpt_nxt   = cpt + WIDTH'(1);
          end
        end
        DONE: begin
          if (start_i && mode_ok) begin
            state_nxt     = RUN;
            cpt_nxt       = init_sel;
            start_idx_nxt = init_sel;
          end else begin
            state_nxt = IDLE;
            err_nxt   = start_i;
          end
        end
        default: begin
          state_nxt = IDLE;
          cpt_nxt   = '0;
        end
      endcase
    end
  end

  assign cpt_o         = cpt;
  assign busy_o        = (state == RUN);
  assign done_o        = (state == DONE);
  assign first_round_o = (state == RUN) && (cpt == start_idx);
  assign last_round_o  = (state == RUN) && (cpt == LAST);
  assign err_o         = err_q;

endmodule

// File: tb/tb_compteur_rondes_param.sv
// Directed bench for compteur_rondes_param; a second instance with ROUNDS_C=1 covers the single-round run.
module tb_compteur_rondes_param;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       start = 1'b0, start2 = 1'b0;
  logic [1:0] mode = 2'b00, mode2 = 2'b00;
  logic       en = 1'b0, abort = 1'b0;
  logic [3:0] cpt, cpt2;
  logic       busy, first, last, done, err;
  logic       busy2, first2, last2, done2, err2;
  int         checks = 0;
  int         passes = 0;

  always #5 clock = ~clock;

  compteur_rondes_param dut (
    .clock_i(clock), .resetb_i(resetb), .start_i(start), .mode_i(mode),
    .en_i(en), .abort_i(abort), .cpt_o(cpt), .busy_o(busy),
    .first_round_o(first), .last_round_o(last), .done_o(done), .err_o(err)
  );

  compteur_rondes_param #(.ROUNDS_C(1)) dut1 (
    .clock_i(clock), .resetb_i(resetb), .start_i(start2), .mode_i(mode2),
    .en_i(en), .abort_i(abort), .cpt_o(cpt2), .busy_o(busy2),
    .first_round_o(first2), .last_round_o(last2), .done_o(done2), .err_o(err2)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({cpt, busy, first, last, done, err} !== 9'd0)
      $display("FAIL reset_outputs: got cpt=%0d flags=%b required cpt=0 flags=00000", cpt, {busy, first, last, done, err});
    else passes++;
    tick();
    resetb = 1'b1;
    tick();
  endtask

  task automatic test_run_a();
    start = 1'b1; mode = 2'b00; en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({cpt, busy, first, last, done} !== {4'(i), 1'b1, (i == 0), (i == 11), 1'b0})
        $display("FAIL run_a[%0d]: got cpt=%0d b/f/l/d=%b required cpt=%0d b/f/l/d=1%b%b0", i, cpt, {busy, first, last, done}, i, (i == 0), (i == 11));
      else passes++;
      tick();
    end
    checks++;
    if ({done, busy} !== 2'b10) $display("FAIL run_a_done: got done/busy=%b required 10", {done, busy});
    else passes++;
    tick();
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL run_a_idle: got done/busy=%b required 00", {done, busy});
    else passes++;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 2'b01; en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 6; i < 12; i++) begin
      checks++;
      if ({cpt, busy, first} !== {4'(i), 1'b1, (i == 6)})
        $display("FAIL b2b_b[%0d]: got cpt=%0d busy=%b first=%b required cpt=%0d busy=1 first=%b", i, cpt, busy, first, i, (i == 6));
      else passes++;
      tick();
    end
    checks++;
    if (done !== 1'b1) $display("FAIL b2b_done1: got done=%b required 1", done);
    else passes++;
    start = 1'b1; mode = 2'b10;
    tick();
    start = 1'b0;
    for (int i = 4; i < 12; i++) begin
      checks++;
      if ({cpt, busy, first, last, done} !== {4'(i), 1'b1, (i == 4), (i == 11), 1'b0})
        $display("FAIL b2b_c[%0d]: got cpt=%0d b/f/l/d=%b required cpt=%0d b/f/l/d=1%b%b0", i, cpt, {busy, first, last, done}, i, (i == 4), (i == 11));
      else passes++;
      tick();
    end
    checks++;
    if (done !== 1'b1) $display("FAIL b2b_done2: got done=%b required 1", done);
    else passes++;
    tick();
  endtask

  task automatic test_enable_gating();
    int exp_cpt;
    start = 1'b1; mode = 2'b01; en = 1'b1;
    tick();
    start = 1'b0;
    exp_cpt = 6;
    for (int k = 0; k < 40; k++) begin
      en = (k % 3 == 0);
      tick();
      if (en) begin
        if (exp_cpt == 11) begin
          checks++;
          if ({done, busy} !== 2'b10) $display("FAIL gate_done: got done/busy=%b required 10", {done, busy});
          else passes++;
          break;
        end
        exp_cpt++;
      end
      checks++;
      if ({cpt, busy, first, done} !== {4'(exp_cpt), 1'b1, (exp_cpt == 6), 1'b0})
        $display("FAIL gate[%0d]: got cpt=%0d b/f/d=%b required cpt=%0d b/f/d=1%b0", k, cpt, {busy, first, done}, exp_cpt, (exp_cpt == 6));
      else passes++;
    end
    en = 1'b1;
    tick();
  endtask

  task automatic test_errors();
    start = 1'b1; mode = 2'b00; en = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0;
    checks++;
    if ({err, cpt, busy} !== {1'b1, 4'd3, 1'b1}) $display("FAIL err_run: got err=%b cpt=%0d busy=%b required err=1 cpt=3 busy=1", err, cpt, busy);
    else passes++;
    tick();
    checks++;
    if ({err, cpt} !== {1'b0, 4'd4}) $display("FAIL err_run_pulse: got err=%b cpt=%0d required err=0 cpt=4", err, cpt);
    else passes++;
    for (int i = 5; i < 12; i++) tick();
    checks++;
    if ({cpt, last} !== {4'd11, 1'b1}) $display("FAIL err_run_last: got cpt=%0d last=%b required cpt=11 last=1", cpt, last);
    else passes++;
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL err_run_done: got done=%b required 1", done);
    else passes++;
    tick();
    start = 1'b1; mode = 2'b11;
    tick();
    start = 1'b0;
    checks++;
    if ({err, busy} !== 2'b10) $display("FAIL err_mode11: got err/busy=%b required 10", {err, busy});
    else passes++;
    tick();
    checks++;
    if ({err, busy, cpt} !== {2'b00, 4'd11}) $display("FAIL err_mode11_idle: got err/busy=%b cpt=%0d required 00 cpt=11", {err, busy}, cpt);
    else passes++;
  endtask

  task automatic test_abort_and_reset();
    start = 1'b1; mode = 2'b00; en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (cpt !== 4'd8) $display("FAIL abort_pre: got cpt=%0d required 8", cpt);
    else passes++;
    abort = 1'b1; start = 1'b1; mode = 2'b01;
    tick();
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({cpt, busy, done, err} !== 7'd0) $display("FAIL abort: got cpt=%0d b/d/e=%b required cpt=0 b/d/e=000", cpt, {busy, done, err});
    else passes++;
    tick();
    checks++;
    if ({cpt, busy, done} !== 6'd0) $display("FAIL abort_idle: got cpt=%0d b/d=%b required cpt=0 b/d=00", cpt, {busy, done});
    else passes++;
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (cpt !== 4'd9) $display("FAIL reset_pre: got cpt=%0d required 9", cpt);
    else passes++;
    #2 resetb = 1'b0;
    #1;
    checks++;
    if ({cpt, busy, first, last, done, err} !== 9'd0)
      $display("FAIL async_reset: got cpt=%0d flags=%b required cpt=0 flags=00000", cpt, {busy, first, last, done, err});
    else passes++;
    tick();
    resetb = 1'b1;
    tick();
    checks++;
    if ({cpt, busy, done} !== 6'd0) $display("FAIL reset_idle: got cpt=%0d b/d=%b required cpt=0 b/d=00", cpt, {busy, done});
    else passes++;
  endtask

  task automatic test_single_round();
    start2 = 1'b1; mode2 = 2'b10; en = 1'b1;
    tick();
    start2 = 1'b0;
    checks++;
    if ({cpt2, busy2, first2, last2, done2} !== {4'd11, 4'b1110})
      $display("FAIL single_run: got cpt=%0d b/f/l/d=%b required cpt=11 b/f/l/d=1110", cpt2, {busy2, first2, last2, done2});
    else passes++;
    tick();
    checks++;
    if ({busy2, first2, last2, done2} !== 4'b0001) $display("FAIL single_done: got b/f/l/d=%b required 0001", {busy2, first2, last2, done2});
    else passes++;
    tick();
    checks++;
    if ({busy2, done2} !== 2'b00) $display("FAIL single_idle: got b/d=%b required 00", {busy2, done2});
    else passes++;
  endtask

  initial begin
    test_reset();
    test_run_a();
    test_back_to_back();
    test_enable_gating();
    test_errors();
    test_abort_and_reset();
    test_single_round();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/compteur_rondes_param.md
Name: compteur_rondes_param

Overview:
Parametrised round counter and sequencer for the ASCON permutation datapath. It supersedes the fixed two-init counter. On a start handshake it selects one of three round counts (pa, pb, pb-alt). It then walks the round-constant index up to the last round, gated by en_i, and flags the first round, the last round and completion. It sits between the ASCON control FSM and the permutation round logic and drives the constant-addition index directly.

Parameters:
WIDTH, 4, width of cpt_o; must satisfy 2**WIDTH >= NB_ROUNDS_MAX.
NB_ROUNDS_MAX, 12, total round-constant table size; last index = NB_ROUNDS_MAX-1.
ROUNDS_A, 12, round count for mode 2'b00 (pa); 1..NB_ROUNDS_MAX.
ROUNDS_B, 6, round count for mode 2'b01 (pb, ASCON-128); 1..NB_ROUNDS_MAX.
ROUNDS_C, 8, round count for mode 2'b10 (pb, ASCON-128a); 1..NB_ROUNDS_MAX.

Ports:
clock_i  in  1  system clock, rising edge.
resetb_i  in  1  asynchronous reset, active low.
start_i  in  1  request a new permutation run; sampled with mode_i.
mode_i  in  2  round-count select: 00=A, 01=B, 10=C, 11=reserved.
en_i  in  1  advance enable; counter holds when low.
abort_i  in  1  synchronous abort back to IDLE.
cpt_o  out  WIDTH  current round-constant index.
busy_o  out  1  high in RUN.
first_round_o  out  1  high in RUN while cpt_o equals the start index of the current run.
last_round_o  out  1  high in RUN while cpt_o = NB_ROUNDS_MAX-1.
done_o  out  1  one-cycle pulse after the last round completes.
err_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (resetb_i=0, any time, asynchronous): state IDLE, cpt_o=0, start-index register=0, all flag outputs 0.
- Start index: init = NB_ROUNDS_MAX - ROUNDS_sel, computed in WIDTH bits. Defaults give A→0, B→6, C→4.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- IDLE:
  - start_i=1 with valid mode → RUN next cycle; cpt_o=init, first_round_o=1.
  - start_i=1 with mode 11 → stay IDLE, err_o=1 for one cycle.
  - cpt_o holds its value.
- RUN:
  - en_i=0 → hold cpt_o and all flags.
  - en_i=1 and cpt_o < last → cpt_o+1.
  - en_i=1 and cpt_o = last → DONE next cycle; cpt_o holds last.
- DONE: done_o=1 for exactly this one cycle, busy_o=0.
  - start_i=1 (valid mode) → RUN directly next cycle with the new init (back-to-back, no idle bubble).
  - Otherwise → IDLE.
- start_i in RUN: ignored, err_o pulses one cycle, run continues unaffected.
- abort_i=1 in any state → IDLE next cycle, cpt_o=0, no done_o. abort_i has priority over start_i and en_i.
- Single-round run (ROUNDS_x=1): init = last, so first_round_o and last_round_o are both high in the same RUN cycle.
- The counter never wraps: it never exceeds NB_ROUNDS_MAX-1 and never increments outside RUN.
- Latency: start_i to first RUN cycle = 1 clock. Run length with en_i held high = ROUNDS_sel RUN cycles followed by 1 DONE cycle.

Test Plan:
- Reset, then start_i=1 with mode 00 and en_i=1 held → cpt_o runs 0..11 over 12 cycles; first_round_o only at 0; last_round_o only at 11; done_o pulses once the following cycle; busy_o returns to 0.
- Start with mode 01, then mode 10 issued in the DONE cycle → cpt_o runs 6..11, DONE pulse, then 4..11 immediately with no IDLE cycle between runs.
- Mode 01 run with en_i toggling 1,0,0,1,... → cpt_o advances only on en_i=1 cycles; 6 enabled cycles are needed to reach DONE.
- start_i asserted mid-RUN, and mode 11 asserted in IDLE → err_o pulses one cycle each; the active run is not perturbed; the FSM stays in IDLE for mode 11.
- abort_i together with start_i at cpt_o=8, and resetb_i asserted low mid-run at cpt_o=9 → IDLE, cpt_o=0, no done_o. Reset clears outputs without waiting for a clock edge.
- Override ROUNDS_C=1 → first_round_o and last_round_o are high together at cpt_o=11 for one cycle, followed by done_o.
